// File: rtl/floo_axis_noc_rx_buffer_if.sv
// Bundle of the AXIS receive stream and the two NoC flit channels of the rx buffer.
// FLOO_AXIS_RX_CREDIT_EN adds the per-channel credit return pulses.
interface floo_axis_noc_rx_buffer_if #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned Depth     = 4,
   parameter int unsigned CntWidth  = $clog2(Depth + 1)
);
   logic [DataWidth:0]   axis_tdata_i;
   logic                 axis_tvalid_i;
   logic                 axis_tready_o;
   logic                 req_valid_o;
   logic                 req_ready_i;
   logic [DataWidth-1:0] req_data_o;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [DataWidth-1:0] rsp_data_o;
   logic [CntWidth-1:0]  req_usage_o;
   logic [CntWidth-1:0]  rsp_usage_o;
`ifdef FLOO_AXIS_RX_CREDIT_EN
   logic                 credit_req_o;
   logic                 credit_rsp_o;
`endif

   modport slave (
      input  axis_tdata_i, axis_tvalid_i, req_ready_i, rsp_ready_i,
      output axis_tready_o, req_valid_o, req_data_o, rsp_valid_o, rsp_data_o,
             req_usage_o, rsp_usage_o
`ifdef FLOO_AXIS_RX_CREDIT_EN
      , output credit_req_o, credit_rsp_o
`endif
   );

   modport master (
      output axis_tdata_i, axis_tvalid_i, req_ready_i, rsp_ready_i,
      input  axis_tready_o, req_valid_o, req_data_o, rsp_valid_o, rsp_data_o,
             req_usage_o, rsp_usage_o
`ifdef FLOO_AXIS_RX_CREDIT_EN
      , input credit_req_o, credit_rsp_o
`endif
   );
endinterface

// File: rtl/floo_axis_noc_rx_buffer.sv
// Rx termination of the serial link: steers AXIS beats by hdr bit into req/rsp FIFOs.
// Optional FLOO_AXIS_RX_CREDIT_EN returns one credit pulse per popped flit.
module floo_axis_noc_rx_fifo #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned Depth     = 4,
   parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 full_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o,
   output logic [CntWidth-1:0]  usage_o,
   output logic                 pop_o
);
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Depth-1:0][DataWidth-1:0] mem;
   logic [PtrWidth-1:0]             wr_ptr, rd_ptr;
   logic [CntWidth-1:0]             cnt;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt == CntWidth'(Depth));
   assign valid_o = (cnt != '0);
   assign pop_o   = valid_o & ready_i;
   assign data_o  = mem[rd_ptr];
   assign usage_o = cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_i) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_o)  rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CntWidth'(push_i) - CntWidth'(pop_o);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr] <= data_i;
   end

   a_cnt_max : assert property (@(posedge clk_i) disable iff (rst_i)
      cnt <= CntWidth'(Depth));
   a_data_hold : assert property (@(posedge clk_i) disable iff (rst_i)
      valid_o && !ready_i |=> $stable(data_o));
endmodule

module floo_axis_noc_rx_buffer #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned Depth     = 4,
   parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
   input logic                       clk_i,
   input logic                       rst_i,
   floo_axis_noc_rx_buffer_if.slave  bus
);
   // Channel index equals the hdr value: 1 = request, 0 = response.
   localparam int unsigned NumCh = 2;

   if (Depth < 1) begin : g_depth_chk
      $error("floo_axis_noc_rx_buffer: Depth must be >= 1");
   end

   logic                                sel;
   logic [NumCh-1:0]                    push, pop, full, valid, ready;
   logic [NumCh-1:0][DataWidth-1:0]     rd_data;
   logic [NumCh-1:0][CntWidth-1:0]      usage;

   assign sel   = bus.axis_tdata_i[DataWidth];
   assign ready = {bus.req_ready_i, bus.rsp_ready_i};

   // Full is judged on the registered count only; a same-cycle pop does not free a slot.
   assign bus.axis_tready_o = !full[sel];

   for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
      assign push[ch] = bus.axis_tvalid_i & bus.axis_tready_o & (sel == 1'(ch));

      floo_axis_noc_rx_fifo #(
         .DataWidth (DataWidth),
         .Depth     (Depth),
         .CntWidth  (CntWidth)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push[ch]),
         .data_i  (bus.axis_tdata_i[DataWidth-1:0]),
         .full_o  (full[ch]),
         .valid_o (valid[ch]),
         .ready_i (ready[ch]),
         .data_o  (rd_data[ch]),
         .usage_o (usage[ch]),
         .pop_o   (pop[ch])
      );
   end

   assign bus.req_valid_o = valid[1];
   assign bus.req_data_o  = rd_data[1];
   assign bus.req_usage_o = usage[1];
   assign bus.rsp_valid_o = valid[0];
   assign bus.rsp_data_o  = rd_data[0];
   assign bus.rsp_usage_o = usage[0];

`ifdef FLOO_AXIS_RX_CREDIT_EN
   logic [NumCh-1:0] credit_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) credit_q <= '0;
      else       credit_q <= pop;
   end

   assign bus.credit_req_o = credit_q[1];
   assign bus.credit_rsp_o = credit_q[0];

   // A credit-respecting transmitter never offers a beat to a full channel.
   a_credit_overrun : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.axis_tvalid_i |-> !full[sel]);
`endif
endmodule

// File: tb/tb_floo_axis_noc_rx_buffer.sv
// Directed bench for floo_axis_noc_rx_buffer with a queue-based reference model
// checked every cycle, plus literal spot checks on each scenario.
module tb_floo_axis_noc_rx_buffer;
   localparam int DW = 64;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   floo_axis_noc_rx_buffer_if #(.DataWidth(DW), .Depth(DP)) bus ();
   floo_axis_noc_rx_buffer #(.DataWidth(DW), .Depth(DP)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int errs   = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one queue per channel, capacity DP.
   logic [DW-1:0] req_q[$];
   logic [DW-1:0] rsp_q[$];
   logic exp_cr_req = 1'b0;
   logic exp_cr_rsp = 1'b0;

   always @(negedge clk) begin : model
      logic hdr, pop_req, pop_rsp, push_req, push_rsp;
      hdr = bus.axis_tdata_i[DW];
      check("m_req_valid", 64'(bus.req_valid_o), 64'(req_q.size() != 0));
      check("m_rsp_valid", 64'(bus.rsp_valid_o), 64'(rsp_q.size() != 0));
      if (req_q.size() != 0) check("m_req_data", bus.req_data_o, req_q[0]);
      if (rsp_q.size() != 0) check("m_rsp_data", bus.rsp_data_o, rsp_q[0]);
      check("m_req_usage", 64'(bus.req_usage_o), 64'(req_q.size()));
      check("m_rsp_usage", 64'(bus.rsp_usage_o), 64'(rsp_q.size()));
      check("m_tready", 64'(bus.axis_tready_o),
            64'(hdr ? (req_q.size() < DP) : (rsp_q.size() < DP)));
`ifdef FLOO_AXIS_RX_CREDIT_EN
      check("m_credit_req", 64'(bus.credit_req_o), 64'(exp_cr_req));
      check("m_credit_rsp", 64'(bus.credit_rsp_o), 64'(exp_cr_rsp));
`endif
      pop_req  = (req_q.size() != 0) && bus.req_ready_i;
      pop_rsp  = (rsp_q.size() != 0) && bus.rsp_ready_i;
      push_req = bus.axis_tvalid_i &&  hdr && (req_q.size() < DP);
      push_rsp = bus.axis_tvalid_i && !hdr && (rsp_q.size() < DP);
      if (rst) begin
         req_q.delete();
         rsp_q.delete();
         exp_cr_req = 1'b0;
         exp_cr_rsp = 1'b0;
      end else begin
         if (pop_req) void'(req_q.pop_front());
         if (pop_rsp) void'(rsp_q.pop_front());
         if (push_req) req_q.push_back(bus.axis_tdata_i[DW-1:0]);
         if (push_rsp) rsp_q.push_back(bus.axis_tdata_i[DW-1:0]);
         exp_cr_req = pop_req;
         exp_cr_rsp = pop_rsp;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW:0] beats[8];
      int idx, cyc;
      logic acc;

      bus.axis_tvalid_i = 1'b0;
      bus.axis_tdata_i  = '0;
      bus.req_ready_i   = 1'b0;
      bus.rsp_ready_i   = 1'b0;
      tick();
      tick();

      // Basic routing and one-cycle latency
      rst = 1'b0;
      bus.req_ready_i = 1'b1;
      bus.rsp_ready_i = 1'b1;
      bus.axis_tvalid_i = 1'b1;
      bus.axis_tdata_i  = {1'b1, 64'hAA};
      @(negedge clk);
      check("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      check("rst_req_usage", 64'(bus.req_usage_o), 64'd0);
      check("rst_rsp_usage", 64'(bus.rsp_usage_o), 64'd0);
      tick();
      bus.axis_tdata_i = {1'b0, 64'hBB};
      @(negedge clk);
      check("t1_req_valid", 64'(bus.req_valid_o), 64'd1);
      check("t1_req_data", bus.req_data_o, 64'hAA);
      check("t1_rsp_valid_early", 64'(bus.rsp_valid_o), 64'd0);
      tick();
      bus.axis_tvalid_i = 1'b0;
      @(negedge clk);
      check("t1_req_drained", 64'(bus.req_valid_o), 64'd0);
      check("t1_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("t1_rsp_data", bus.rsp_data_o, 64'hBB);
      tick();
      @(negedge clk);
      check("t1_req_usage0", 64'(bus.req_usage_o), 64'd0);
      check("t1_rsp_usage0", 64'(bus.rsp_usage_o), 64'd0);

      // Fill request FIFO; response beats must still flow
      tick();
      bus.req_ready_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      bus.axis_tvalid_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         bus.axis_tdata_i = {1'b1, 64'(k)};
         tick();
      end
`ifndef FLOO_AXIS_RX_CREDIT_EN
      bus.axis_tdata_i = {1'b1, 64'd5};
      @(negedge clk);
      check("t2_req_full_usage", 64'(bus.req_usage_o), 64'd4);
      check("t2_tready_full", 64'(bus.axis_tready_o), 64'd0);
      tick();
`endif
      bus.axis_tdata_i = {1'b0, 64'h55};
      @(negedge clk);
      check("t2_tready_rsp", 64'(bus.axis_tready_o), 64'd1);
      tick();
      bus.axis_tvalid_i = 1'b0;
      @(negedge clk);
      check("t2_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("t2_rsp_data", bus.rsp_data_o, 64'h55);
      check("t2_req_usage", 64'(bus.req_usage_o), 64'd4);

      // Drain request FIFO in order across the pointer wrap
      tick();
      bus.req_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 4) check("t3_req_order", bus.req_data_o, 64'(i + 1));
         else       check("t3_req_valid_low", 64'(bus.req_valid_o), 64'd0);
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      tick();

      // Alternating hdr stream with rsp_ready toggling 1010
      for (int i = 0; i < 8; i++) beats[i] = {(i % 2 == 0) ? 1'b1 : 1'b0, 64'(256 + i)};
      idx = 0;
      cyc = 0;
      bus.req_ready_i = 1'b1;
      while (idx < 8 && cyc < 60) begin
         bus.axis_tvalid_i = 1'b1;
         bus.axis_tdata_i  = beats[idx];
         bus.rsp_ready_i   = (cyc % 2 == 0);
         @(negedge clk);
         acc = bus.axis_tready_o;
         tick();
         cyc++;
         if (acc) idx++;
      end
      check("t4_all_accepted", 64'(idx), 64'd8);
      bus.axis_tvalid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      check("t4_req_usage0", 64'(bus.req_usage_o), 64'd0);
      check("t4_rsp_usage0", 64'(bus.rsp_usage_o), 64'd0);

      // Reset with three flits buffered
      tick();
      bus.req_ready_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      bus.axis_tvalid_i = 1'b1;
      bus.axis_tdata_i = {1'b1, 64'h31}; tick();
      bus.axis_tdata_i = {1'b0, 64'h32}; tick();
      bus.axis_tdata_i = {1'b1, 64'h33}; tick();
      bus.axis_tvalid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t5_pre_req_usage", 64'(bus.req_usage_o), 64'd2);
      check("t5_pre_rsp_usage", 64'(bus.rsp_usage_o), 64'd1);
      tick();
      rst = 1'b0;
      bus.axis_tvalid_i = 1'b1;
      bus.axis_tdata_i = {1'b1, 64'h77};
      @(negedge clk);
      check("t5_req_valid", 64'(bus.req_valid_o), 64'd0);
      check("t5_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      check("t5_req_usage", 64'(bus.req_usage_o), 64'd0);
      check("t5_rsp_usage", 64'(bus.rsp_usage_o), 64'd0);
      check("t5_tready", 64'(bus.axis_tready_o), 64'd1);
      tick();
      bus.axis_tvalid_i = 1'b0;
      @(negedge clk);
      check("t5_new_valid", 64'(bus.req_valid_o), 64'd1);
      check("t5_new_data", bus.req_data_o, 64'h77);
      tick();
      bus.req_ready_i = 1'b1;
      tick();
      tick();

`ifdef FLOO_AXIS_RX_CREDIT_EN
      // Three back-to-back pops give three consecutive credit pulses
      bus.req_ready_i = 1'b0;
      bus.axis_tvalid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.axis_tdata_i = {1'b1, 64'(65 + k)};
         tick();
      end
      bus.axis_tvalid_i = 1'b0;
      bus.req_ready_i = 1'b1;
      @(negedge clk);
      check("t6_credit_idle", 64'(bus.credit_req_o), 64'd0);
      tick();
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("t6_credit_req", 64'(bus.credit_req_o), 64'd1);
         check("t6_credit_rsp", 64'(bus.credit_rsp_o), 64'd0);
         tick();
      end
      @(negedge clk);
      check("t6_credit_end", 64'(bus.credit_req_o), 64'd0);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
